// File: rtl/core_if_fetch.sv
// rtl/core_if_fetch.sv - instruction-fetch stage: PC, one-outstanding imem request, IF/ID handoff.
// Optional IF_RESP_BYPASS_EN delivers imem_rdata straight from WAIT when ID is not stalled.
module core_if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_plus_4,
    output logic [31:0] inst_word,
    output logic        if_id_we,
    output logic        if_flush
);

    typedef enum logic [1:0] {REQ, WAIT, VALID, DROP} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_inst_buf;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_buf_nxt;
    logic [31:0] w_pc_plus_4;
    logic        w_deliver;

    assign w_pc_plus_4 = r_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= REQ;
            r_pc       <= RESET_PC;
            r_inst_buf <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_inst_buf <= w_buf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_buf_nxt   = r_inst_buf;
        w_deliver   = 1'b0;
        inst_word   = r_inst_buf;
        case (r_state)
            REQ: begin
                // An ack alongside a redirect means the old-path request is already in flight.
                if (imem_ack) w_state_nxt = redirect_valid ? DROP : WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (redirect_valid) begin
                        w_state_nxt = REQ;
`ifdef IF_RESP_BYPASS_EN
                    end else if (!stall) begin
                        w_deliver   = 1'b1;
                        inst_word   = imem_rdata;
                        w_pc_nxt    = w_pc_plus_4;
                        w_state_nxt = REQ;
`endif
                    end else begin
                        w_buf_nxt   = imem_rdata;
                        w_state_nxt = VALID;
                    end
                end else if (redirect_valid) begin
                    w_state_nxt = DROP;
                end
            end
            VALID: begin
                if (redirect_valid) begin
                    w_state_nxt = REQ;
                end else if (!stall) begin
                    w_deliver   = 1'b1;
                    w_pc_nxt    = w_pc_plus_4;
                    w_state_nxt = REQ;
                end
            end
            DROP: begin
                // The discarded response retires the outstanding request, even if redirected again.
                if (imem_rvalid) w_state_nxt = REQ;
            end
            default: w_state_nxt = REQ;
        endcase
        if (redirect_valid) w_pc_nxt = redirect_pc & ~32'd3;
    end

    assign imem_req  = (r_state == REQ) && !rst;
    assign imem_addr = {r_pc[31:2], 2'b00};
    assign pc_plus_4 = w_pc_plus_4;
    assign if_id_we  = w_deliver && !rst;
    assign if_flush  = redirect_valid && !rst;

endmodule

// File: tb/tb_core_if_fetch.sv
// tb/tb_core_if_fetch.sv - scoreboard bench for core_if_fetch with a behavioural instruction memory.
module tb_core_if_fetch;

`ifdef IF_RESP_BYPASS_EN
    localparam int EXP_GAP = 2;
`else
    localparam int EXP_GAP = 3;
`endif

    logic        clk;
    logic        rst, stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_ack, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata, pc_plus_4, inst_word;
    logic        if_id_we, if_flush;

    logic        rst2, stall2, redirect_valid2, imem_ack2, imem_rvalid2;
    logic [31:0] redirect_pc2, imem_rdata2;
    logic        imem_req2, if_id_we2, if_flush2;
    logic [31:0] imem_addr2, pc_plus_4_2, inst_word2;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [63:0] exp_q[$];
    logic [31:0] data_q[$];
    logic [31:0] ack_log[$];
    int          deliv_cyc[$];
    int          rdelay;
    int          rv_cnt = 0;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] pend_data = '0;

    core_if_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc_plus_4(pc_plus_4), .inst_word(inst_word), .if_id_we(if_id_we), .if_flush(if_flush)
    );

    core_if_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .rst(rst2), .stall(stall2), .redirect_valid(redirect_valid2),
        .redirect_pc(redirect_pc2), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack2), .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
        .pc_plus_4(pc_plus_4_2), .inst_word(inst_word2), .if_id_we(if_id_we2), .if_flush(if_flush2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_inst(input logic [31:0] pc4, input logic [31:0] inst);
        exp_q.push_back({pc4, inst});
    endtask

    task automatic wait_drained(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Behavioural memory: acks when it has data queued, answers rdelay cycles after the ack.
    always @(posedge clk) begin
        #2;
        imem_ack    = 1'b0;
        imem_rvalid = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else if (pend) begin
            if (cnt <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = pend_data;
                pend        = 1'b0;
                rv_cnt++;
            end else begin
                cnt--;
            end
        end else if (imem_req && data_q.size() > 0) begin
            imem_ack  = 1'b1;
            pend      = 1'b1;
            cnt       = rdelay;
            pend_data = data_q.pop_front();
            ack_log.push_back(imem_addr);
        end
    end

    always @(negedge clk) begin
        if (!rst && if_id_we) begin
            deliv_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_delivery: got inst %h pc_plus_4 %h expected none", inst_word, pc_plus_4);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("deliver_pc_plus_4", pc_plus_4, e[63:32]);
                chk("deliver_inst", inst_word, e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_acks[$];
        int          rv0;
        int          gap;
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; rdelay = 1;
        rst2 = 1'b1; stall2 = 1'b0; redirect_valid2 = 1'b0; redirect_pc2 = '0;
        imem_ack2 = 1'b0; imem_rvalid2 = 1'b0; imem_rdata2 = '0;

        // Reset state, with a redirect asserted to confirm flush is masked.
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0040;
        @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_we", {31'd0, if_id_we}, 32'd0);
        chk("rst_flush", {31'd0, if_flush}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_inst", inst_word, 32'h0);
        chk("rst_pc_plus_4", pc_plus_4, 32'h4);
        step();
        redirect_valid = 1'b0;

        // Back-to-back fetches at 0x0 and 0x4.
        step();
        data_q.push_back(32'h8C01_0004);
        data_q.push_back(32'h2022_0001);
        expect_inst(32'h4, 32'h8C01_0004);
        expect_inst(32'h8, 32'h2022_0001);
        rst = 1'b0;
        wait_drained(40);
        if (deliv_cyc.size() >= 2) gap = deliv_cyc[1] - deliv_cyc[0];
        else gap = -1;
        chk("throughput_gap", gap, EXP_GAP);

        // Stall held four cycles in VALID.
        step();
        data_q.push_back(32'h1111_1111);
        expect_inst(32'hC, 32'h1111_1111);
        stall = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            @(negedge clk);
            if (i >= 2) begin
                chk("stall_we", {31'd0, if_id_we}, 32'd0);
                chk("stall_req", {31'd0, imem_req}, 32'd0);
                chk("stall_inst", inst_word, 32'h1111_1111);
            end
        end
        step();
        stall = 1'b0;
        @(negedge clk);
        chk("stall_release_we", {31'd0, if_id_we}, 32'd1);
        step();
        @(negedge clk);
        chk("stall_next_addr", imem_addr, 32'hC);
        chk("stall_next_req", {31'd0, imem_req}, 32'd1);

        // Redirect during WAIT; the late 0xDEADBEEF must be dropped.
        step();
        data_q.push_back(32'hDEAD_BEEF);
        data_q.push_back(32'hAAAA_0001);
        expect_inst(32'h104, 32'hAAAA_0001);
        rdelay = 3;
        step();
        rdelay = 1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(negedge clk);
        chk("wait_redir_flush", {31'd0, if_flush}, 32'd1);
        chk("wait_redir_we", {31'd0, if_id_we}, 32'd0);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("drop_flush_clear", {31'd0, if_flush}, 32'd0);
        chk("drop_req", {31'd0, imem_req}, 32'd0);
        step();
        step();
        @(negedge clk);
        chk("wait_redir_addr", imem_addr, 32'h100);
        chk("wait_redir_req", {31'd0, imem_req}, 32'd1);
        wait_drained(40);

        // Redirect and stall together in VALID.
        step();
        data_q.push_back(32'h2222_2222);
        stall = 1'b1;
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0400;
        @(negedge clk);
        chk("valid_redir_we", {31'd0, if_id_we}, 32'd0);
        chk("valid_redir_flush", {31'd0, if_flush}, 32'd1);
        step();
        stall = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("valid_redir_addr", imem_addr, 32'h400);
        chk("valid_redir_req", {31'd0, imem_req}, 32'd1);
        step();
        data_q.push_back(32'h3333_3333);
        expect_inst(32'h404, 32'h3333_3333);
        wait_drained(40);

        // Two redirects while in DROP; newest target wins, one response discarded.
        step();
        data_q.push_back(32'h4444_4444);
        rdelay = 4;
        step();
        rdelay = 1;
        rv0 = rv_cnt;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();
        redirect_pc = 32'h0000_0300;
        @(negedge clk);
        chk("drop2_req", {31'd0, imem_req}, 32'd0);
        step();
        redirect_valid = 1'b0;
        step();
        step();
        data_q.push_back(32'h5555_5555);
        expect_inst(32'h304, 32'h5555_5555);
        @(negedge clk);
        chk("drop2_addr", imem_addr, 32'h300);
        chk("drop2_discarded", rv_cnt - rv0, 32'd1);
        wait_drained(40);

        exp_acks = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h104, 32'h400, 32'h404, 32'h300};
        chk("ack_count", ack_log.size(), exp_acks.size());
        for (int i = 0; i < exp_acks.size() && i < ack_log.size(); i++)
            chk($sformatf("ack_addr_%0d", i), ack_log[i], exp_acks[i]);

        // Wrapping PC on the second instance.
        step();
        rst2 = 1'b0;
        imem_ack2 = 1'b1;
        @(negedge clk);
        chk("wrap_req", {31'd0, imem_req2}, 32'd1);
        chk("wrap_addr", imem_addr2, 32'hFFFF_FFFC);
        step();
        imem_ack2 = 1'b0;
        imem_rvalid2 = 1'b1;
        imem_rdata2 = 32'h6666_6666;
        @(negedge clk);
`ifdef IF_RESP_BYPASS_EN
        chk("wrap_we", {31'd0, if_id_we2}, 32'd1);
        chk("wrap_pc_plus_4", pc_plus_4_2, 32'h0);
        chk("wrap_inst", inst_word2, 32'h6666_6666);
`endif
        step();
        imem_rvalid2 = 1'b0;
        @(negedge clk);
`ifndef IF_RESP_BYPASS_EN
        chk("wrap_we", {31'd0, if_id_we2}, 32'd1);
        chk("wrap_pc_plus_4", pc_plus_4_2, 32'h0);
        chk("wrap_inst", inst_word2, 32'h6666_6666);
`endif
        step();
        @(negedge clk);
        chk("wrap_next_addr", imem_addr2, 32'h0);
        chk("wrap_next_req", {31'd0, imem_req2}, 32'd1);

        // Reset while WAIT is outstanding.
        step();
        imem_ack2 = 1'b1;
        step();
        imem_ack2 = 1'b0;
        rst2 = 1'b1;
        redirect_valid2 = 1'b1;
        @(negedge clk);
        chk("rst_wait_req", {31'd0, imem_req2}, 32'd0);
        chk("rst_wait_we", {31'd0, if_id_we2}, 32'd0);
        chk("rst_wait_flush", {31'd0, if_flush2}, 32'd0);
        step();
        rst2 = 1'b0;
        redirect_valid2 = 1'b0;
        @(negedge clk);
        chk("rst_wait_addr", imem_addr2, 32'hFFFF_FFFC);
        chk("rst_wait_req_after", {31'd0, imem_req2}, 32'd1);
        chk("rst_wait_we_after", {31'd0, if_id_we2}, 32'd0);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/core_if_fetch.md
Name: core_if_fetch

Overview:
- Instruction-fetch stage of each ring-network core; sits directly upstream of the IF/ID pipeline register.
- Owns the PC and issues one instruction request at a time to the core's instruction memory / I-cache port over a req/ack + rvalid handshake.
- Presents pc_plus_4, inst_word and the write-enable/flush controls that the IF/ID register consumes.
- Applies branch/jump redirects and hazard stalls from later stages.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  hazard unit: ID cannot accept a new instruction this cycle.
- redirect_valid  in  1  branch/jump taken; fetch must restart at redirect_pc.
- redirect_pc  in  32  redirect target; bits [1:0] ignored and treated as 0.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address, word aligned.
- imem_ack  in  1  memory accepted the request this cycle.
- imem_rvalid  in  1  read data valid; at most one per accepted request, at least 1 cycle after ack.
- imem_rdata  in  32  instruction word.
- pc_plus_4  out  32  address of delivered instruction + 4.
- inst_word  out  32  delivered instruction.
- if_id_we  out  1  IF/ID load enable.
- if_flush  out  1  IF/ID clear (wrong-path squash).

Behaviour:
- Registers: pc_q[31:0], inst_buf[31:0], 2-bit state {REQ, WAIT, VALID, DROP}.
- Reset values: pc_q=RESET_PC, state=REQ, inst_buf=0. Reset overrides everything, including mid-transaction.
- While rst is high: imem_req=0, if_id_we=0, if_flush=0.
- A response to a request accepted before or during reset is not tracked. The memory side is reset together with this block.
- imem_addr = {pc_q[31:2],2'b00}.
- imem_req = (state==REQ) && !rst.
- Only one request is outstanding at any time.
- pc_plus_4 = pc_q + 4, mod 2^32; 32'hFFFF_FFFC wraps to 0.
- inst_word = inst_buf.
- if_id_we = (state==VALID) && !stall && !redirect_valid.
- if_flush = redirect_valid && !rst (combinational).
- REQ:
  - imem_ack -> WAIT.
  - Otherwise stay in REQ.
  - Address may change while unacknowledged; memory samples it only on the ack cycle.
- WAIT:
  - imem_rvalid -> inst_buf<=imem_rdata, go to VALID.
- VALID:
  - if_id_we=1 -> pc_q<=pc_q+4, go to REQ.
  - stall holds VALID, with inst_buf and pc_q unchanged.
- DROP:
  - Wait for the discarded response. imem_rvalid -> REQ; data is ignored.
- Redirect rule: redirect_valid has priority over stall and always loads pc_q<=redirect_pc & ~3. Next state per current state:
  - REQ with imem_ack the same cycle: old-address request is in flight -> DROP.
  - REQ without ack: stay in REQ.
  - WAIT with imem_rvalid the same cycle: data discarded -> REQ.
  - WAIT without rvalid: -> DROP.
  - VALID: buffer discarded -> REQ.
  - DROP: stay in DROP; the newest redirect_pc wins.
- Consequence: no wrong-path instruction is ever delivered with if_id_we=1 after a redirect.
- Baseline throughput: REQ, WAIT, VALID; 3 cycles per instruction with ack in the REQ cycle and rvalid on the next cycle.

Optional Feature:
- Macro: IF_RESP_BYPASS_EN.
- With the macro defined:
  - In WAIT, an imem_rvalid cycle with !stall && !redirect_valid delivers directly: inst_word=imem_rdata, if_id_we=1, pc_q<=pc_q+4, next state REQ.
  - Throughput becomes 2 cycles per instruction.
  - If stall is high in that cycle, behaviour falls back to capture into inst_buf and go to VALID.
- Without the macro: inst_word always comes from inst_buf and delivery only occurs from VALID.

Test Plan:
- Reset, then ack in REQ and rvalid one cycle later with rdata 0x8C010004, 0x20220001 -> imem_addr 0x0 then 0x4; inst_word 0x8C010004 with pc_plus_4=0x4, then 0x20220001 with pc_plus_4=0x8; if_id_we one cycle each, 3 cycles apart (2 with IF_RESP_BYPASS_EN).
- stall high for 4 cycles while in VALID -> if_id_we=0, inst_word stable, imem_req=0; one cycle after stall drops, if_id_we=1 and imem_addr advances by 4.
- redirect_valid with redirect_pc=0x103 while in WAIT; late rvalid returns 0xDEADBEEF -> if_flush=1 for that cycle; DEADBEEF never delivered; next imem_addr=0x100; next delivered pc_plus_4=0x104.
- redirect and stall together in VALID -> redirect wins: if_id_we=0, if_flush=1, next request to the redirect target.
- Two redirects (0x200 then 0x300) while in DROP -> exactly one discarded response; next request to 0x300.
- RESET_PC=32'hFFFF_FFFC -> first delivery pc_plus_4=0, next imem_addr=0; rst asserted in WAIT -> state REQ, imem_addr=RESET_PC, no if_id_we.
